// File: rtl/alu_ctl_pipe.sv
// alu_ctl_pipe: registered, valid/ready ALU control decoder for the execute stage.
// Decodes {opcode, func_code} into a 7-bit ALU control word one cycle after accept.
// Optionally sequences multi-cycle RV32M ops with a latency counter.
//
// Build option: define ALU_CTL_RV32M_EN to enable RV32M decode, the BUSY state and
// the latency counter. Without it, RV32M encodings decode as illegal single-cycle NOPs.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous kill of any held or in-flight operation
//   in_valid   decode presents an instruction
//   in_ready   block can accept this cycle
//   opcode     instr[6:0]
//   func_code  {instr[25], instr[30], instr[14:12]}
//   out_valid  alu_ctl/illegal valid for execute
//   out_ready  execute consumes the output
//   alu_ctl    [6:4] condition / M-funct3, [3:0] operation; upper bits zero
//   busy       multi-cycle count in progress
//   illegal    undecodable opcode/func combination (qualified by out_valid)
module alu_ctl_pipe #(
    parameter int unsigned CTL_WIDTH  = 7,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [4:0]           func_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTL_WIDTH-1:0] alu_ctl,
    output logic                 busy,
    output logic                 illegal
);

    if (CTL_WIDTH < 7 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
        $error("alu_ctl_pipe: CTL_WIDTH must be >= 7 and latencies >= 1");
    end

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSrl  = 4'b0011;
    localparam logic [3:0] OpSra  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpXor  = 4'b1000;
    localparam logic [3:0] OpCsrw = 4'b1001;
    localparam logic [3:0] OpCsrs = 4'b1010;
    localparam logic [3:0] OpCsrc = 4'b1011;
    localparam logic [3:0] OpSltu = 4'b1100;
    localparam logic [3:0] OpNop  = 4'b1111;
`ifdef ALU_CTL_RV32M_EN
    localparam logic [3:0] OpMul  = 4'b1101;
    localparam logic [3:0] OpDiv  = 4'b1110;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

    state_e     state_q;
    logic [6:0] ctl_q;
    logic       ill_q;
    logic       out_valid_q;

    logic [2:0] f3;
    logic [3:0] dec_op;
    logic [2:0] dec_cond;
    logic       dec_ill;
    logic       accept;

    assign f3 = func_code[2:0];

`ifdef ALU_CTL_RV32M_EN
    localparam int unsigned MaxLat = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = (MaxLat > 2) ? $clog2(MaxLat) : 1;

    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic            dec_mop;
    logic            dec_div;
    logic [31:0]     lat;

    assign lat  = dec_div ? DIV_CYCLES : MUL_CYCLES;
    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    // Combinational decode; only ever sampled into registers on accept.
    always_comb begin
        dec_op   = OpNop;
        dec_cond = 3'b000;
        dec_ill  = 1'b0;
`ifdef ALU_CTL_RV32M_EN
        dec_mop  = 1'b0;
        dec_div  = 1'b0;
`endif
        case (opcode)
            7'b0110111, 7'b0010111: dec_op = OpAdd;          // LUI, AUIPC
            7'b0000011: begin                                // loads
                if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_op = OpAdd;
                else dec_ill = 1'b1;
            end
            7'b0100011: begin                                // stores
                if (f3 inside {3'b000, 3'b001, 3'b010}) dec_op = OpAdd;
                else dec_ill = 1'b1;
            end
            7'b1100011: begin                                // branches compare via SUB
                dec_op = OpSub;
                case (f3)
                    3'b000:  dec_cond = 3'b001;
                    3'b001:  dec_cond = 3'b010;
                    3'b100:  dec_cond = 3'b011;
                    3'b101:  dec_cond = 3'b100;
                    3'b110:  dec_cond = 3'b101;
                    3'b111:  dec_cond = 3'b110;
                    default: begin
                        dec_op  = OpNop;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            7'b1101111, 7'b1100111: dec_op = OpNop;          // JAL, JALR
            7'b0010011: begin                                // OP-IMM
                case (f3)
                    3'b000:  dec_op = OpAdd;
                    3'b001:  dec_op = OpSll;
                    3'b010:  dec_op = OpSlt;
                    3'b011:  dec_op = OpSltu;
                    3'b100:  dec_op = OpXor;
                    3'b101:  dec_op = func_code[3] ? OpSra : OpSrl;
                    3'b110:  dec_op = OpOr;
                    default: dec_op = OpAnd;
                endcase
            end
            7'b0110011: begin                                // OP
                if (func_code[4]) begin
`ifdef ALU_CTL_RV32M_EN
                    dec_mop  = 1'b1;
                    dec_div  = f3[2];
                    dec_op   = f3[2] ? OpDiv : OpMul;
                    dec_cond = f3;
`else
                    dec_ill  = 1'b1;
`endif
                end else if (func_code[3] && f3 != 3'b000 && f3 != 3'b101) begin
                    dec_ill = 1'b1;
                end else begin
                    case (f3)
                        3'b000:  dec_op = func_code[3] ? OpSub : OpAdd;
                        3'b001:  dec_op = OpSll;
                        3'b010:  dec_op = OpSlt;
                        3'b011:  dec_op = OpSltu;
                        3'b100:  dec_op = OpXor;
                        3'b101:  dec_op = func_code[3] ? OpSra : OpSrl;
                        3'b110:  dec_op = OpOr;
                        default: dec_op = OpAnd;
                    endcase
                end
            end
            7'b1110011: begin                                // SYSTEM
                case (f3[1:0])
                    2'b01:   dec_op = OpCsrw;
                    2'b10:   dec_op = OpCsrs;
                    2'b11:   dec_op = OpCsrc;
                    default: dec_op = OpNop;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // HOLD with out_ready lets a new op replace the retiring one in the same cycle.
    assign in_ready = !flush && (state_q == StIdle || (state_q == StHold && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ctl_q       <= {3'b000, OpNop};
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_CTL_RV32M_EN
            busy_q      <= 1'b0;
            cnt_q       <= '0;
`endif
        end else if (flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
`ifdef ALU_CTL_RV32M_EN
            busy_q      <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
`ifdef ALU_CTL_RV32M_EN
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_q     <= StHold;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Accept overrides the retire transition above.
            if (accept) begin
                ctl_q <= {dec_cond, dec_op};
                ill_q <= dec_ill;
`ifdef ALU_CTL_RV32M_EN
                if (dec_mop && lat > 32'd1) begin
                    state_q     <= StBusy;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b1;
                    cnt_q       <= CntW'(lat - 32'd2);
                end else begin
                    state_q     <= StHold;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
`else
                state_q     <= StHold;
                out_valid_q <= 1'b1;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = ill_q;
    assign alu_ctl   = CTL_WIDTH'(ctl_q);

endmodule

// File: tb/tb_alu_ctl_pipe.sv
// Directed self-checking bench for alu_ctl_pipe. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_alu_ctl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [4:0] func_code;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] alu_ctl;
    logic       busy;
    logic       illegal;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcImm   = 7'b0010011;
    localparam logic [6:0] OpcBr    = 7'b1100011;
    localparam logic [6:0] OpcJal   = 7'b1101111;
    localparam logic [6:0] OpcFence = 7'b0001111;
    localparam logic [6:0] OpcSys   = 7'b1110011;

    alu_ctl_pipe #(
        .CTL_WIDTH (7),
        .MUL_CYCLES(2),
        .DIV_CYCLES(33)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .func_code(func_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_ctl  (alu_ctl),
        .busy     (busy),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] fc);
        in_valid  = v;
        opcode    = op;
        func_code = fc;
    endtask

    // Single op with out_ready=1; checks result one cycle after accept.
    task automatic single(input string tag, input logic [6:0] op, input logic [4:0] fc,
                          input logic [6:0] exp_ctl, input logic exp_ill);
        drive(1'b1, op, fc);
        step();
        drive(1'b0, 7'd0, 5'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_ctl"}, {25'd0, alu_ctl}, {25'd0, exp_ctl});
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
        step();
    endtask

    initial begin
        int busy_cnt;
        int valid_at;

        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 7'd0, 5'd0);
        step();
        check("rst_ctl", {25'd0, alu_ctl}, 32'b0001111);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ill", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        step();
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back ADD, SUB, BGEU with out_ready held high.
        drive(1'b1, OpcOp, 5'b00000);
        step();
        check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_add_ctl", {25'd0, alu_ctl}, 32'b0000010);
        check("b2b_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, OpcOp, 5'b01000);
        step();
        check("b2b_sub_ctl", {25'd0, alu_ctl}, 32'b0000110);
        drive(1'b1, OpcBr, 5'b00111);
        step();
        check("b2b_bgeu_ctl", {25'd0, alu_ctl}, 32'b1100110);
        check("b2b_bgeu_ill", {31'd0, illegal}, 32'd0);
        drive(1'b0, 7'd0, 5'd0);
        step();
        check("b2b_idle_valid", {31'd0, out_valid}, 32'd0);

        // SLTIU held under back-pressure; a pending ADD must not be taken.
        out_ready = 1'b0;
        drive(1'b1, OpcImm, 5'b00011);
        step();
        drive(1'b1, OpcOp, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ctl", {25'd0, alu_ctl}, 32'b0001100);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        drive(1'b0, 7'd0, 5'd0);
        out_ready = 1'b1;
        step();
        check("hold_release", {31'd0, out_valid}, 32'd0);

        // DIVU latency / illegal handling.
        drive(1'b1, OpcOp, 5'b10101);
        step();
        drive(1'b0, 7'd0, 5'd0);
`ifdef ALU_CTL_RV32M_EN
        busy_cnt = 0;
        valid_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (out_valid && valid_at == 0) begin
                valid_at = k;
                check("divu_ctl", {25'd0, alu_ctl}, 32'b1011110);
                check("divu_ill", {31'd0, illegal}, 32'd0);
            end
            step();
        end
        check("divu_busy_cycles", busy_cnt, 32);
        check("divu_valid_at", valid_at, 33);
        // Flush at T+10 kills the division.
        drive(1'b1, OpcOp, 5'b10101);
        step();
        drive(1'b0, 7'd0, 5'd0);
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("divu_flush_valid", {31'd0, out_valid}, 32'd0);
        check("divu_flush_busy", {31'd0, busy}, 32'd0);
        check("divu_flush_ready", {31'd0, in_ready}, 32'd1);
        valid_at = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid || busy) valid_at++;
            step();
        end
        check("divu_flush_quiet", valid_at, 0);
`else
        check("divu_valid", {31'd0, out_valid}, 32'd1);
        check("divu_ctl", {25'd0, alu_ctl}, 32'b0001111);
        check("divu_ill", {31'd0, illegal}, 32'd1);
        check("divu_busy", {31'd0, busy}, 32'd0);
        step();
        check("divu_retire", {31'd0, out_valid}, 32'd0);
`endif

        // Flush kills a held output and blocks a same-cycle accept.
        out_ready = 1'b0;
        drive(1'b1, OpcOp, 5'b00000);
        step();
        drive(1'b1, OpcOp, 5'b01000);
        flush = 1'b1;
        #1;
        check("flush_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 7'd0, 5'd0);
        out_ready = 1'b1;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_ctl_kept", {25'd0, alu_ctl}, 32'b0000010);

        // Miscellaneous decodes.
        single("fence", OpcFence, 5'b00000, 7'b0001111, 1'b1);
        single("jal", OpcJal, 5'b00000, 7'b0001111, 1'b0);
        single("bne", OpcBr, 5'b00001, 7'b0100110, 1'b0);
        single("op_bad_sub", OpcOp, 5'b01001, 7'b0001111, 1'b1);
        single("csrrs", OpcSys, 5'b00010, 7'b0001010, 1'b0);
        single("srai", OpcImm, 5'b01101, 7'b0000100, 1'b0);
        single("slt", OpcOp, 5'b00010, 7'b0000111, 1'b0);

        // Reset asserted mid-stream (BUSY with RV32M, HOLD otherwise).
        out_ready = 1'b0;
        drive(1'b1, OpcOp, 5'b10101);
        step();
        drive(1'b0, 7'd0, 5'd0);
        step();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ctl", {25'd0, alu_ctl}, 32'b0001111);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_ctl_pipe.md
# alu_ctl_pipe

Registered, handshaked successor to the combinational ALU control decoder. Accepts {opcode, func code} from decode on a valid/ready interface, produces the 7-bit-compatible ALU control word one cycle later, and sequences multi-cycle RV32M operations with a latency counter so the execute stage sees a stall-aware `out_valid`. Sits between the decode register and the ALU/mul-div unit in the execute stage.

## Interface
- `CTL_WIDTH`, 7, width of `alu_ctl`; must be ≥7; bits above [6] always driven 0.
- `MUL_CYCLES`, 2, cycles from accept to `out_valid` for MUL/MULH/MULHSU/MULHU; must be ≥1.
- `DIV_CYCLES`, 33, cycles from accept to `out_valid` for DIV/DIVU/REM/REMU; must be ≥1.
- `clk` in 1 clock, rising edge.
- `reset` in 1 asynchronous, active-high reset.
- `flush` in 1 synchronous kill of any held or in-flight operation.
- `in_valid` in 1 decode has an instruction.
- `in_ready` out 1 block can accept this cycle.
- `opcode` in 7 instr[6:0].
- `func_code` in 5 {instr[25], instr[30], instr[14:12]}.
- `out_valid` out 1 `alu_ctl` valid for execute.
- `out_ready` in 1 execute consumes output.
- `alu_ctl` out CTL_WIDTH [6:4] condition / M-funct3, [3:0] operation.
- `busy` out 1 multi-cycle count in progress.
- `illegal` out 1 qualified by `out_valid`; opcode/func combination not decodable.

## Operation
- Op field [3:0]: AND 0000, OR 0001, ADD 0010, SRL 0011, SRA 0100, SLL 0101, SUB 0110, SLT 0111, XOR 1000, CSRRW 1001, CSRRS 1010, CSRRC 1011, SLTU 1100, MUL group 1101, DIV group 1110, NOP 1111.
- Condition field [6:4] for branches (op SUB): BEQ 001, BNE 010, BLT 011, BGE 100, BLTU 101, BGEU 110; 000 otherwise.
- LUI, AUIPC, loads (funct3 000/001/010/100/101), stores (000/001/010), ADDI → ADD. JAL, JALR → NOP, not illegal.
- OP-IMM/OP decode as standard RV32I; SLTIU/SLTU → SLTU (distinct from SLT). func_code[3] selects SUB/SRA(I); OP with func_code[3]=1 on funct3 ∉ {000,101} → illegal.
- SYSTEM (1110011): funct3[1:0] 01/10/11 → CSRRW/CSRRS/CSRRC; 00 → NOP, not illegal.
- Any other opcode or unlisted funct3 → NOP, `illegal`=1.
- OP with func_code[4]=1 (RV32M): funct3[2]=0 → MUL group, else DIV group; [6:4] carries funct3.
- FSM states IDLE, BUSY, HOLD.
  - IDLE: `in_ready`=1. Accept (`in_valid`) → single-cycle op: HOLD; M op: BUSY, counter loads latency−2 (latency 1 → HOLD directly).
  - BUSY: `in_ready`=0, `busy`=1, `out_valid`=0; counter decrements; at 0 → HOLD.
  - HOLD: `out_valid`=1. `out_ready`=1 retires; `in_ready`=`out_ready` (back-to-back accept replaces output, re-enters HOLD/BUSY). `out_ready`=0 holds output stable.
- `flush`: next state IDLE, `out_valid`=0, counter cleared; overrides same-cycle accept (`in_ready` forced 0 while `flush`=1).

## Timing
- Reset (async): state IDLE, `alu_ctl`=NOP (7'b0001111, upper bits 0), `out_valid`=0, `busy`=0, `illegal`=0, counter 0; `in_ready`=1 after reset deasserts.
- Single-cycle op accepted at edge T → `out_valid` from T+1.
- M op accepted at T → `out_valid` at T+MUL_CYCLES / T+DIV_CYCLES; `busy` high in between.
- Throughput 1/cycle for single-cycle ops with `out_ready` held 1.
- Outputs registered; no combinational path from `opcode`/`func_code` to outputs. `in_ready` depends combinationally only on state, `out_ready`, `flush`.
- Reset mid-BUSY aborts immediately; no output produced.

## Configuration
- `ALU_CTL_RV32M_EN` defined: RV32M decode, BUSY state, counter present as above.
- Undefined: func_code[4]=1 on OP → NOP with `illegal`=1, single-cycle; BUSY unreachable, `busy` tied 0, counter and latency parameters unused.

## Test plan
- Reset asserted mid-stream → `alu_ctl`=7'b0001111, `out_valid`=0, `in_ready`=1 once released.
- Back-to-back ADD (0110011/00000), SUB (01000), BGEU (1100011/00111) with `out_ready`=1 → `alu_ctl` 0000010, 0000110, 1100110 on consecutive cycles.
- SLTIU with `out_ready`=0 for 3 cycles → `alu_ctl`=0001100 held stable, `in_ready`=0 until release.
- With macro, DIVU (0110011/10101), DIV_CYCLES=33 → `busy` 32 cycles, `out_valid` at T+33, `alu_ctl`=1011110; `flush` at T+10 → no output, IDLE next cycle.
- Without macro, same DIVU → T+1 `alu_ctl`=0001111, `illegal`=1, `busy`=0.
- Opcode 0001111 → NOP, `illegal`=1; JAL → NOP, `illegal`=0.
